// File: rtl/rpn_sequencer.sv
// rpn_sequencer: buffers RPN instructions in a small FIFO and issues each one
// to the stack calculator as a setup / strobe / hold sequence, checking stack
// depth first and reporting top-of-stack on END.
module rpn_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int DATA_W     = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [2:0]               in_op,
  input  logic signed [DATA_W-1:0] in_data,
  output logic                     calc_step,
  output logic                     calc_push,
  output logic [1:0]               calc_op,
  output logic signed [DATA_W-1:0] calc_d,
  input  logic signed [DATA_W-1:0] calc_out,
  input  logic [9:0]               calc_cnt,
  output logic                     res_valid,
  output logic signed [DATA_W-1:0] res_data,
  output logic [9:0]               res_depth,
  output logic                     busy,
  output logic                     err,
  output logic [1:0]               err_code,
  input  logic                     err_clr
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW+1)'(FIFO_DEPTH);
  localparam logic [9:0]  STACK_MAX = 10'd1023;

  localparam logic [2:0] OP_PUSH = 3'd0;
  localparam logic [2:0] OP_NEG  = 3'd1;
  localparam logic [2:0] OP_ADD  = 3'd2;
  localparam logic [2:0] OP_MUL  = 3'd3;
  localparam logic [2:0] OP_END  = 3'd4;

  localparam logic [1:0] ERR_UNDER   = 2'b01;
  localparam logic [1:0] ERR_OVER    = 2'b10;
  localparam logic [1:0] ERR_ILLEGAL = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_REPORT, S_ERROR
  } state_t;

  state_t state, state_n;

  logic [2:0]               fifo_op  [FIFO_DEPTH];
  logic signed [DATA_W-1:0] fifo_dat [FIFO_DEPTH];
  logic [AW:0]              wr_ptr, rd_ptr, fifo_cnt, fifo_cnt_n;
  logic                     full, empty, push_en, pop_en, flush;
  logic [2:0]               head_op;
  logic signed [DATA_W-1:0] head_dat;

  logic [2:0]               cmd_op;
  logic signed [DATA_W-1:0] cmd_dat;
  logic [2:0]               sel_op;
  logic signed [DATA_W-1:0] sel_dat;

  logic                     drv_push;
  logic [1:0]               drv_op;
  logic signed [DATA_W-1:0] drv_d;
  logic [1:0]               code_n;

  assign fifo_cnt = wr_ptr - rd_ptr;
  assign full     = (fifo_cnt == FULL_CNT);
  assign empty    = (fifo_cnt == '0);
  assign head_op  = fifo_op[rd_ptr[AW-1:0]];
  assign head_dat = fifo_dat[rd_ptr[AW-1:0]];

  // Acceptance ignores a same-cycle pop, and is held off during reset and flush.
  assign in_ready = !full && !rst && !err_clr;
  assign push_en  = in_valid && in_ready;
  assign pop_en   = (state == S_IDLE) && !empty;
  assign flush    = (state == S_ERROR) && err_clr;

  // Instruction storage; contents need no reset, the pointers define validity.
  always_ff @(posedge clk) begin
    if (push_en) begin
      fifo_op[wr_ptr[AW-1:0]]  <= in_op;
      fifo_dat[wr_ptr[AW-1:0]] <= in_data;
    end
  end

  // FIFO pointers; a flush drops everything queued (no write can coincide).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      rd_ptr <= wr_ptr;
    end else begin
      if (push_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop_en)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Command register captures the FIFO head as it is popped.
  always_ff @(posedge clk) begin
    if (pop_en) begin
      cmd_op  <= head_op;
      cmd_dat <= head_dat;
    end
  end

  // Next state, error code and next calculator drive.
  always_comb begin
    state_n  = state;
    code_n   = err_code;
    drv_push = 1'b0;
    drv_op   = 2'b00;
    drv_d    = '0;
    sel_op   = (state == S_IDLE) ? head_op  : cmd_op;
    sel_dat  = (state == S_IDLE) ? head_dat : cmd_dat;
    fifo_cnt_n = flush ? '0
               : fifo_cnt + {{AW{1'b0}}, push_en} - {{AW{1'b0}}, pop_en};

    case (state)
      S_IDLE: begin
        if (!empty) begin
          case (head_op)
            OP_PUSH: if (calc_cnt == STACK_MAX) begin
                       state_n = S_ERROR; code_n = ERR_OVER;
                     end else state_n = S_SETUP;
            OP_NEG:  if (calc_cnt == 10'd0) begin
                       state_n = S_ERROR; code_n = ERR_UNDER;
                     end else state_n = S_SETUP;
            OP_ADD, OP_MUL:
                     if (calc_cnt < 10'd2) begin
                       state_n = S_ERROR; code_n = ERR_UNDER;
                     end else state_n = S_SETUP;
            OP_END:  state_n = S_REPORT;
            default: begin state_n = S_ERROR; code_n = ERR_ILLEGAL; end
          endcase
        end
      end
      S_SETUP:  state_n = S_STROBE;
      S_STROBE: state_n = S_HOLD;
      S_HOLD:   state_n = S_IDLE;
      S_REPORT: state_n = S_IDLE;
      S_ERROR: begin
        if (err_clr) begin
          state_n = S_IDLE;
          code_n  = 2'b00;
        end
      end
      default:  state_n = S_IDLE;
    endcase

    if (state_n == S_SETUP || state_n == S_STROBE || state_n == S_HOLD) begin
      case (sel_op)
        OP_PUSH: begin drv_push = 1'b1; drv_d = sel_dat; end
        OP_NEG:  drv_op = 2'b01;
        OP_ADD:  drv_op = 2'b10;
        OP_MUL:  drv_op = 2'b11;
        default: drv_op = 2'b00;
      endcase
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= S_IDLE;
      calc_step <= 1'b0;
      calc_push <= 1'b0;
      calc_op   <= 2'b00;
      calc_d    <= '0;
      res_valid <= 1'b0;
      res_data  <= '0;
      res_depth <= '0;
      busy      <= 1'b0;
      err       <= 1'b0;
      err_code  <= 2'b00;
    end else begin
      state     <= state_n;
      calc_step <= (state_n == S_STROBE);
      calc_push <= drv_push;
      calc_op   <= drv_op;
      calc_d    <= drv_d;
      res_valid <= (state_n == S_REPORT);
      if (state == S_IDLE && state_n == S_REPORT) begin
        res_data  <= calc_out;
        res_depth <= calc_cnt;
      end
      busy      <= (state_n != S_IDLE) || (fifo_cnt_n != '0);
      err       <= (state_n == S_ERROR);
      err_code  <= code_n;
    end
  end

endmodule

// File: tb/tb_rpn_sequencer.sv
// tb_rpn_sequencer: drives RPN programs into rpn_sequencer, emulates the stack
// calculator, and checks every strobe and result against a reference model.
module tb_rpn_sequencer;

  logic clk;
  logic rst;
  logic in_valid, err_clr;
  logic [2:0] in_op;
  logic signed [15:0] in_data;
  logic in_ready, calc_step, calc_push, res_valid, busy, err;
  logic [1:0] calc_op, err_code;
  logic signed [15:0] calc_d, calc_out, res_data;
  logic [9:0] calc_cnt, res_depth;

  rpn_sequencer #(.FIFO_DEPTH(4), .DATA_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_op(in_op), .in_data(in_data), .calc_step(calc_step),
    .calc_push(calc_push), .calc_op(calc_op), .calc_d(calc_d),
    .calc_out(calc_out), .calc_cnt(calc_cnt), .res_valid(res_valid),
    .res_data(res_data), .res_depth(res_depth), .busy(busy), .err(err),
    .err_code(err_code), .err_clr(err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Calculator stand-in: acts on each strobe, reset together with the sequencer.
  logic signed [15:0] stk [1024];
  logic [10:0] ccnt;
  logic [9:0]  top_i, nxt_i;
  assign top_i    = 10'(ccnt - 11'd1);
  assign nxt_i    = 10'(ccnt - 11'd2);
  assign calc_out = (ccnt != 0) ? stk[top_i] : 16'sd0;
  assign calc_cnt = ccnt[9:0];

  always @(posedge clk or posedge rst) begin
    if (rst) ccnt <= '0;
    else if (calc_step) begin
      if (calc_push) begin
        stk[ccnt[9:0]] <= calc_d;
        ccnt <= ccnt + 11'd1;
      end else begin
        case (calc_op)
          2'b01: if (ccnt >= 1) stk[top_i] <= -stk[top_i];
          2'b10: if (ccnt >= 2) begin stk[nxt_i] <= stk[nxt_i] + stk[top_i]; ccnt <= ccnt - 11'd1; end
          2'b11: if (ccnt >= 2) begin stk[nxt_i] <= stk[nxt_i] * stk[top_i]; ccnt <= ccnt - 11'd1; end
          default: ;
        endcase
      end
    end
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an RPN stack evaluated at instruction acceptance time.
  typedef struct packed { logic push; logic [1:0] op; logic [15:0] d; } step_t;
  typedef struct packed { logic [15:0] data; logic [9:0] depth; } res_t;
  step_t exp_steps[$];
  res_t  exp_res[$];
  logic signed [15:0] mstk[$];
  logic m_err;
  logic [1:0] m_code;

  function automatic void model_reset();
    exp_steps.delete();
    exp_res.delete();
    mstk.delete();
    m_err  = 1'b0;
    m_code = 2'b00;
  endfunction

  function automatic void model_accept(input logic [2:0] op, input logic signed [15:0] d);
    logic signed [15:0] a, b, r;
    if (m_err) return;
    case (op)
      3'd0: if (mstk.size() == 1023) begin m_err = 1; m_code = 2'b10; end
            else begin exp_steps.push_back('{1'b1, 2'b00, d}); mstk.push_back(d); end
      3'd1: if (mstk.size() == 0) begin m_err = 1; m_code = 2'b01; end
            else begin
              exp_steps.push_back('{1'b0, 2'b01, 16'd0});
              mstk[mstk.size()-1] = -mstk[mstk.size()-1];
            end
      3'd2, 3'd3:
            if (mstk.size() < 2) begin m_err = 1; m_code = 2'b01; end
            else begin
              exp_steps.push_back('{1'b0, op[1:0], 16'd0});
              a = mstk.pop_back();
              b = mstk.pop_back();
              r = (op == 3'd2) ? a + b : a * b;
              mstk.push_back(r);
            end
      3'd4: exp_res.push_back('{(mstk.size() != 0) ? mstk[mstk.size()-1] : 16'sd0,
                                10'(mstk.size())});
      default: begin m_err = 1; m_code = 2'b11; end
    endcase
  endfunction

  // Compare process: every strobe, result and error output against the model.
  int n_steps = 0;
  int n_res = 0;
  logic [1:0] ops_seen[$];
  logic [15:0] last_res_data;
  logic [9:0]  last_res_depth;
  logic hold_pending;
  logic h_push, p_push;
  logic [1:0] h_op, p_op;
  logic [15:0] h_d, p_d;

  initial begin
    step_t e;
    res_t  r;
    hold_pending = 0;
    p_push = 0; p_op = 0; p_d = 0;
    forever begin
      @(negedge clk);
      if (rst) hold_pending = 0;
      else begin
        if (hold_pending) begin
          check("hold_stable", {calc_step, calc_push, calc_op, calc_d}, {1'b0, h_push, h_op, h_d});
          hold_pending = 0;
        end
        if (calc_step) begin
          n_steps++;
          ops_seen.push_back(calc_op);
          check("setup_stable", {p_push, p_op, p_d}, {calc_push, calc_op, calc_d});
          if (exp_steps.size() == 0) check("step_unexpected", 1, 0);
          else begin
            e = exp_steps.pop_front();
            check("step_cmd", {calc_push, calc_op, calc_d}, {e.push, e.op, e.d});
          end
          hold_pending = 1;
          h_push = calc_push; h_op = calc_op; h_d = calc_d;
        end
        if (res_valid) begin
          n_res++;
          last_res_data = res_data;
          last_res_depth = res_depth;
          if (exp_res.size() == 0) check("res_unexpected", 1, 0);
          else begin
            r = exp_res.pop_front();
            check("res_value", {res_data, res_depth}, {r.data, r.depth});
          end
        end
        if (err) begin
          check("err_code", {m_err, err_code}, {1'b1, m_code});
          check("err_no_step", calc_step, 0);
        end else begin
          check("err_code_idle", err_code, 0);
        end
      end
      p_push = calc_push; p_op = calc_op; p_d = calc_d;
    end
  end

  // Stimulus helpers
  int n_notready = 0;

  task automatic send(input logic [2:0] op, input logic signed [15:0] d, input bit last = 1);
    bit ok;
    ok = 0;
    @(negedge clk);
    in_valid = 1; in_op = op; in_data = d;
    for (int t = 0; t < 200; t++) begin
      if (in_ready) begin
        @(posedge clk);
        model_accept(op, d);
        ok = 1;
        break;
      end
      n_notready++;
      @(negedge clk);
    end
    if (!ok) check("send_timeout", 0, 1);
    if (last) begin #1; in_valid = 0; end
  endtask

  task automatic wait_idle(input int max);
    bit ok;
    ok = 0;
    for (int t = 0; t < max; t++) begin
      @(negedge clk); #1;
      if (!busy && exp_steps.size() == 0 && exp_res.size() == 0) begin ok = 1; break; end
    end
    check("idle_reached", ok, 1);
  endtask

  task automatic wait_err(input int max);
    bit ok;
    ok = 0;
    for (int t = 0; t < max; t++) begin
      @(negedge clk); #1;
      if (err) begin ok = 1; break; end
    end
    check("err_reached", ok, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_in_ready"}, in_ready, 0);
    check({tag, "_ctrl"}, {calc_step, calc_push, calc_op, res_valid, busy, err, err_code}, 0);
    check({tag, "_calc_d"}, calc_d, 0);
    check({tag, "_res"}, {res_data, res_depth}, 0);
  endtask

  task automatic do_reset();
    in_valid = 0; err_clr = 0;
    @(negedge clk);
    rst = 1;
    model_reset();
    #1 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    check("reset_release_ready", in_ready, 1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int s0;
    rst = 0; in_valid = 0; err_clr = 0; in_op = 0; in_data = 0;
    model_reset();

    // PUSH 3, PUSH 4, ADD, END
    do_reset();
    s0 = n_steps;
    send(3'd0, 16'sd3); send(3'd0, 16'sd4); send(3'd2, 16'sd0); send(3'd4, 16'sd0);
    wait_idle(100);
    check("t1_steps", n_steps - s0, 3);
    check("t1_res_count", n_res, 1);
    check("t1_res_data", last_res_data, 16'd7);
    check("t1_res_depth", last_res_depth, 10'd1);
    check("t1_err", err, 0);

    // PUSH 5, PUSH -6, MUL, NEG, END
    do_reset();
    ops_seen.delete();
    send(3'd0, 16'sd5); send(3'd0, -16'sd6); send(3'd3, 16'sd0); send(3'd1, 16'sd0);
    send(3'd4, 16'sd0);
    wait_idle(100);
    check("t2_res_data", last_res_data, 16'd30);
    check("t2_res_depth", last_res_depth, 10'd1);
    check("t2_nops", ops_seen.size(), 4);
    if (ops_seen.size() == 4) begin
      check("t2_op0", ops_seen[0], 2'b00);
      check("t2_op1", ops_seen[1], 2'b00);
      check("t2_op2", ops_seen[2], 2'b11);
      check("t2_op3", ops_seen[3], 2'b01);
    end

    // ADD on empty stack, then queue more, then clear
    do_reset();
    s0 = n_steps;
    send(3'd2, 16'sd0);
    wait_err(50);
    check("t3_code", err_code, 2'b01);
    send(3'd0, 16'sd1); send(3'd0, 16'sd2);
    repeat (8) @(negedge clk);
    check("t3_no_step", n_steps - s0, 0);
    check("t3_still_err", err, 1);
    @(negedge clk);
    err_clr = 1;
    #1 check("t3_ready_during_clr", in_ready, 0);
    @(posedge clk);
    m_err = 0; m_code = 0;
    @(negedge clk);
    err_clr = 0;
    #1;
    check("t3_err_cleared", {err, err_code}, 0);
    check("t3_busy", busy, 0);
    check("t3_ready", in_ready, 1);
    repeat (10) @(negedge clk);
    check("t3_flushed_no_step", n_steps - s0, 0);
    check("t3_calc_cnt", calc_cnt, 0);

    // Six back-to-back PUSHes with in_valid held
    do_reset();
    s0 = n_steps;
    n_notready = 0;
    for (int i = 1; i <= 6; i++) send(3'd0, 16'(i), i == 6);
    wait_idle(100);
    check("t4_backpressure", n_notready != 0, 1);
    check("t4_steps", n_steps - s0, 6);
    check("t4_calc_cnt", calc_cnt, 6);
    for (int i = 0; i < 6; i++) check("t4_order", stk[i], 16'(i + 1));

    // Illegal opcode
    do_reset();
    s0 = n_steps;
    send(3'd6, 16'sd0);
    wait_err(50);
    check("t5_code", err_code, 2'b11);
    check("t5_no_step", n_steps - s0, 0);

    // Overflow: 1023 PUSHes then one more
    do_reset();
    for (int i = 0; i < 1023; i++) send(3'd0, 16'(i), 0);
    send(3'd0, 16'sd7, 1);
    wait_err(100);
    check("t6_code", err_code, 2'b10);
    check("t6_drained", exp_steps.size(), 0);
    repeat (6) @(negedge clk);
    check("t6_calc_cnt", calc_cnt, 10'd1023);

    // Reset during STROBE
    do_reset();
    send(3'd0, 16'sd9); send(3'd0, 16'sd10);
    begin
      bit seen;
      seen = 0;
      for (int t = 0; t < 50; t++) begin
        @(posedge clk); #1;
        if (calc_step) begin seen = 1; break; end
      end
      check("t7_strobe_seen", seen, 1);
    end
    rst = 1;
    model_reset();
    #1 check_reset_outputs("t7_async");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 0;
    @(posedge clk); #1;
    check("t7_ready_after", in_ready, 1);
    s0 = n_steps;
    repeat (10) @(negedge clk);
    check("t7_fifo_empty", {busy, 1'b0}, 0);
    check("t7_no_step", n_steps - s0, 0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/rpn_sequencer.md
# rpn_sequencer

Command sequencer for the stack calculator datapath (top register, stack memory, address pointer, operate unit). Accepts a stream of RPN instructions over a valid/ready interface, buffers them in a small FIFO, and issues each one to the calculator as a setup/strobe/hold sequence on its `push`/`op`/`d`/`step` inputs. Checks stack depth before every command, blocks on underflow/overflow/illegal opcodes, and reports the top-of-stack on an END instruction.

## Interface
- FIFO_DEPTH, 4, instruction FIFO entries; power of two, ≥2
- clk  in  1  system clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  instruction offered
- in_ready  out  1  FIFO can accept; transfer when in_valid && in_ready
- in_op  in  3  000 PUSH, 001 NEG, 010 ADD, 011 MUL, 100 END, 101–111 illegal
- in_data  in  16  signed push operand; ignored unless PUSH
- calc_step  out  1  calculator step strobe, one clk cycle high per command
- calc_push  out  1  calculator push
- calc_op  out  2  calculator op: 00 NONE, 01 NEG, 10 ADD, 11 MUL
- calc_d  out  16  calculator data input
- calc_out  in  16  calculator top-of-stack
- calc_cnt  in  10  calculator stack depth
- res_valid  out  1  one-cycle result pulse
- res_data  out  16  calc_out sampled at END
- res_depth  out  10  calc_cnt sampled at END
- busy  out  1  state ≠ IDLE or FIFO non-empty
- err  out  1  sticky error flag
- err_code  out  2  01 underflow, 10 overflow, 11 illegal opcode; 00 when err=0
- err_clr  in  1  clears error and flushes FIFO; honoured only in ERROR

## Operation
- FIFO: FIFO_DEPTH × 19 bits (op + data), in-order. in_ready = !full && state-independent, except forced 0 while rst or err_clr is high. No push into a full FIFO even if a pop occurs in the same cycle.
- States: IDLE, SETUP, STROBE, HOLD, REPORT, ERROR.
- IDLE: if FIFO non-empty, pop head into command register at the same edge and decode against current calc_cnt:
  - NEG with calc_cnt=0, or ADD/MUL with calc_cnt<2 → ERROR, err_code 01.
  - PUSH with calc_cnt=1023 → ERROR, err_code 10.
  - op 101–111 → ERROR, err_code 11.
  - END → REPORT (empty stack is legal: reports calc_out, depth 0).
  - otherwise → SETUP.
- SETUP: drive calc_push/calc_op/calc_d from command (PUSH: push=1, op=00, d=data; NEG/ADD/MUL: push=0, op=01/10/11, d=0); calc_step=0.
- STROBE: same drive, calc_step=1.
- HOLD: same drive, calc_step=0; → IDLE.
- REPORT: res_valid=1, res_data=calc_out, res_depth=calc_cnt (registered); → IDLE.
- ERROR: err=1, no strobes; FIFO keeps accepting until full. err_clr=1 → flush FIFO, clear err/err_code, → IDLE. err_clr outside ERROR: ignored.
- In IDLE/REPORT/ERROR: calc_push=0, calc_op=00, calc_d=0, calc_step=0.
- Top level ties calculator nrst to !rst; this block never resets the calculator itself.

## Timing
- Reset values: in_ready 0 during rst, 1 the cycle after; calc_step, calc_push, calc_op, calc_d, res_valid, res_data, res_depth, busy, err, err_code all 0; FIFO empty; state IDLE.
- All outputs registered except in_ready.
- Arithmetic command: 4 cycles from pop to next pop (IDLE, SETUP, STROBE, HOLD). END: 2 cycles. Input-to-first-strobe latency from empty FIFO: 3 cycles.
- calc_push/calc_op/calc_d stable one cycle before, during, and one cycle after calc_step; calc_cnt is read only in IDLE, after the previous HOLD.
- rst mid-command: everything returns to reset values asynchronously; queued instructions lost.

## Test plan
- PUSH 3, PUSH 4, ADD, END → three calc_step pulses, res_valid one cycle with res_data=7, res_depth=1, err=0.
- PUSH 5, PUSH −6, MUL, NEG, END → res_data=30, res_depth=1; calc_op sequence 00,00,11,01.
- ADD on empty stack → err=1, err_code=01, no calc_step; queue 2 more ops, pulse err_clr → err=0, busy=0, FIFO empty, in_ready=1.
- in_valid held with 6 PUSHes back-to-back (FIFO_DEPTH=4) → in_ready deasserts while full, all 6 values pushed in order, calc_cnt=6, no loss or duplication.
- Opcode 110 → err_code=11; separately 1023 PUSHes then PUSH → err_code=10, calc_cnt stays 1023.
- Assert rst during STROBE → calc_step and all outputs 0 immediately, FIFO empty, in_ready 1 the cycle after release.
